pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Instruction-cycle controller for the 8-bit program counter: fetch → decode/operand fetch → execute.
- Generates the PC increment, load and 2-bit source-select controls, plus instruction-register and operand-register load strobes.
- Owns a down-growing return stack in data memory (CALL/RET) with overflow and underflow detection.
- Sits between the instruction decoder and the PC/data-memory datapath.

Parameters:
- SP_INIT, 8'hFF, stack-pointer reset value; SP == SP_INIT means the stack is empty.
- SP_LIMIT, 8'hF0, lowest legal SP; a CALL with SP == SP_LIMIT is an overflow (15 entries with the defaults).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  freeze the FSM and SP; forces all strobes to 0.
- HAS_OPND  in  1  decoder: the instruction carries an 8-bit operand byte (sampled in DECODE).
- BR_TYPE  in  3  decoder class, sampled in DECODE and held for EXEC: 000 NONE, 001 JMP, 010 JCC, 011 JR0, 100 CALL, 101 RET, 110 HLT, 111 treated as NONE.
- COND  in  3  {neg, sel[1:0]}; sel: 00 Z, 01 C, 10 S, 11 always; neg inverts the selected condition.
- FLAGS  in  3  {S, C, Z} from the ALU, sampled in EXEC.
- PC_IN  in  8  current PC value (the PC register output).
- I_PC  out  1  PC increment strobe.
- L_PC  out  1  PC load strobe.
- S11, S10  out  1 each  PC source select: 01 operand, 10 DM, 11 R0, 00 hold.
- IR_LD  out  1  load the instruction register.
- OPND_LD  out  1  load the operand register.
- EX_EN  out  1  datapath execute enable for NONE-class instructions.
- DM_WE, DM_RE  out  1 each  data-memory write / read strobes (stack traffic only).
- DM_ADDR  out  8  stack address.
- DM_WDATA  out  8  pushed return address.
- SP_OUT  out  8  current stack pointer.
- HALTED  out  1  FSM is in HALT.
- STK_ERR  out  1  sticky stack fault flag.

Behaviour:
- Reset (RST=1 at an edge): state←FETCH, SP←SP_INIT, STK_ERR←0, HALTED←0.
- While RST=1, every strobe, S11/S10, DM_ADDR and DM_WDATA are 0. RST overrides STALL and every state, including mid-RET.
- Strobes decode combinationally from the registered state and the registered decode fields.
- The sequencer never asserts I_PC and L_PC together.
- S11/S10 = 00 whenever L_PC = 0.
- STALL=1: state, SP and the registered decode fields hold; all strobes are 0. The state in progress resumes on the first cycle after STALL drops.
- FETCH: IR_LD=1, I_PC=1 → DECODE.
- DECODE:
  - Register BR_TYPE and COND.
  - If HAS_OPND: OPND_LD=1 and I_PC=1.
  - Next state is EXEC. Each instruction takes 3 cycles in the base case.
- EXEC, by BR_TYPE:
  - NONE: EX_EN=1 → FETCH.
  - JMP: L_PC=1, sel 01 → FETCH.
  - JCC: if the condition is true, L_PC=1 with sel 01; otherwise no strobe (the PC already points past the operand). → FETCH.
  - JR0: L_PC=1, sel 11 → FETCH.
  - CALL, SP ≠ SP_LIMIT: DM_WE=1, DM_ADDR=SP−1, DM_WDATA=PC_IN (the return address); SP←SP−1; L_PC=1, sel 01 → FETCH.
  - CALL, SP == SP_LIMIT: no write, no load; STK_ERR←1 → HALT.
  - RET, SP ≠ SP_INIT: DM_RE=1, DM_ADDR=SP → RETLD.
  - RET, SP == SP_INIT: STK_ERR←1 → HALT.
  - HLT: → HALT.
- RETLD: data memory has 1-cycle read latency, so its output is valid here. L_PC=1, sel 10; SP←SP+1 → FETCH. RET takes 4 cycles total.
- HALT: HALTED=1, no strobes. Only RST exits.
- SP arithmetic is 8-bit. The fault checks guarantee SP never wraps.

Decomposition:
- Shared package (rnbip_pkg):
  - BR_TYPE encodings.
  - COND sel encodings.
  - PC select constants: PC_OD=01, PC_DM=10, PC_R0=11.
  - FSM state enum: FETCH, DECODE, EXEC, RETLD, HALT.
- One natural sub-module: pc_cond_eval, a combinational evaluator of COND against FLAGS returning 1 bit.

Test Plan:
- Reset, then NONE with HAS_OPND=0 → cycles 1–3 show IR_LD+I_PC, nothing, EX_EN; the PC advances by 1.
- JMP with operand 8'h40 at PC 8'h10 → DECODE shows OPND_LD+I_PC; EXEC shows L_PC=1, S11S10=01; the next FETCH runs at PC 8'h40.
- JCC with COND=3'b000 (Z): FLAGS Z=0 → no L_PC and the PC continues at 8'h12; FLAGS Z=1 → L_PC=1. Repeat with COND=3'b100 and check the inverted results.
- CALL 8'h80 from PC 8'h20, then RET:
  - CALL EXEC: DM_WE=1, DM_ADDR=8'hFE, DM_WDATA=8'h22, SP_OUT=8'hFE.
  - RET: DM_RE=1 at 8'hFE; in RETLD, L_PC=1, S11S10=10; SP returns to 8'hFF.
- Faults:
  - RET from reset → STK_ERR=1, HALTED=1, no DM strobes.
  - 15 nested CALLs succeed; the 16th (SP=8'hF0) → STK_ERR=1, HALT, no DM_WE.
  - RST=1 then releases HALT with SP=8'hFF.
- STALL=1 for 3 cycles during EXEC of CALL → no strobes and SP unchanged; the push occurs on the first unstalled cycle. RST asserted during RETLD → next state FETCH with SP=SP_INIT.

Source files
------------

// File: rtl/rnbip_pkg.sv
// Purpose : shared encodings for the PC sequencer (decoder classes, condition selects,
//           PC source selects, FSM states, flag bit positions).
// Latency : n/a (types and constants only).  Backpressure: n/a.
package rnbip_pkg;

    // Decoder instruction class, as presented on BR_TYPE.
    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JMP  = 3'b001,
        BR_JCC  = 3'b010,
        BR_JR0  = 3'b011,
        BR_CALL = 3'b100,
        BR_RET  = 3'b101,
        BR_HLT  = 3'b110,
        BR_RSV  = 3'b111   // reserved, behaves as NONE
    } br_type_e;

    // COND[1:0] selects which flag is tested; COND[2] inverts it.
    typedef enum logic [1:0] {
        CS_Z  = 2'b00,
        CS_C  = 2'b01,
        CS_S  = 2'b10,
        CS_AL = 2'b11
    } cond_sel_e;

    // PC source select {S11,S10}.
    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_OD   = 2'b01;
    localparam logic [1:0] PC_DM   = 2'b10;
    localparam logic [1:0] PC_R0   = 2'b11;

    // Bit positions inside FLAGS = {S, C, Z}.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_RETLD  = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/pc_cond_eval.sv
// Purpose : evaluates a branch condition {neg, sel[1:0]} against ALU flags {S, C, Z}.
// Latency : purely combinational.  Backpressure: none.
// Ports   : cond_i (3) condition code, flags_i (3) ALU flags, true_o (1) condition holds.
module pc_cond_eval
    import rnbip_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       true_o
);

    logic flag_sel;

    always_comb begin
        flag_sel = 1'b1;
        case (cond_sel_e'(cond_i[1:0]))
            CS_Z:    flag_sel = flags_i[FLAG_Z];
            CS_C:    flag_sel = flags_i[FLAG_C];
            CS_S:    flag_sel = flags_i[FLAG_S];
            CS_AL:   flag_sel = 1'b1;
            default: flag_sel = 1'b1;
        endcase
    end

    // The negate bit applies to "always" too, giving a never-taken JCC.
    assign true_o = flag_sel ^ cond_i[2];

endmodule

// File: rtl/pc_sequencer.sv
// Purpose : instruction-cycle controller for the 8-bit PC: FETCH -> DECODE -> EXEC
//           (-> RETLD for RET), plus a down-growing return stack in data memory.
// Latency : 3 cycles per instruction, 4 for RET; strobes are combinational from state.
// Backpressure: STALL freezes state, SP and decode fields and zeroes every strobe.
// Ports   : CLK/RST (sync, active-high); STALL; decoder inputs HAS_OPND, BR_TYPE, COND;
//           FLAGS {S,C,Z}; PC_IN; PC controls I_PC, L_PC, S11/S10; IR_LD, OPND_LD, EX_EN;
//           stack port DM_WE, DM_RE, DM_ADDR, DM_WDATA; status SP_OUT, HALTED, STK_ERR.
module pc_sequencer
    import rnbip_pkg::*;
#(
    parameter logic [7:0] SP_INIT  = 8'hFF,
    parameter logic [7:0] SP_LIMIT = 8'hF0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STALL,
    input  logic       HAS_OPND,
    input  logic [2:0] BR_TYPE,
    input  logic [2:0] COND,
    input  logic [2:0] FLAGS,
    input  logic [7:0] PC_IN,
    output logic       I_PC,
    output logic       L_PC,
    output logic       S11,
    output logic       S10,
    output logic       IR_LD,
    output logic       OPND_LD,
    output logic       EX_EN,
    output logic       DM_WE,
    output logic       DM_RE,
    output logic [7:0] DM_ADDR,
    output logic [7:0] DM_WDATA,
    output logic [7:0] SP_OUT,
    output logic       HALTED,
    output logic       STK_ERR
);

    state_e     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    br_type_e   br_q, br_d;
    logic [2:0] cond_q, cond_d;
    logic       err_q, err_d;

    // Raw strobes before reset gating.
    logic       i_pc, l_pc, ir_ld, opnd_ld, ex_en, dm_we, dm_re;
    logic [1:0] pc_sel;
    logic [7:0] dm_addr, dm_wdata;

    logic       cond_true;

    // Condition uses the decode-time COND but the EXEC-time flags.
    pc_cond_eval u_cond (
        .cond_i  (cond_q),
        .flags_i (FLAGS),
        .true_o  (cond_true)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
            sp_q    <= SP_INIT;
            br_q    <= BR_NONE;
            cond_q  <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            br_q    <= br_d;
            cond_q  <= cond_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        br_d     = br_q;
        cond_d   = cond_q;
        err_d    = err_q;
        i_pc     = 1'b0;
        l_pc     = 1'b0;
        pc_sel   = PC_HOLD;
        ir_ld    = 1'b0;
        opnd_ld  = 1'b0;
        ex_en    = 1'b0;
        dm_we    = 1'b0;
        dm_re    = 1'b0;
        dm_addr  = 8'h00;
        dm_wdata = 8'h00;

        // A stalled cycle leaves every next-state equal to the current one,
        // so the interrupted phase simply replays once STALL drops.
        if (!STALL) begin
            case (state_q)
                ST_FETCH: begin
                    ir_ld   = 1'b1;
                    i_pc    = 1'b1;
                    state_d = ST_DECODE;
                end

                ST_DECODE: begin
                    br_d   = br_type_e'(BR_TYPE);
                    cond_d = COND;
                    if (HAS_OPND) begin
                        opnd_ld = 1'b1;
                        i_pc    = 1'b1;
                    end
                    state_d = ST_EXEC;
                end

                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (br_q)
                        BR_JMP: begin
                            l_pc   = 1'b1;
                            pc_sel = PC_OD;
                        end
                        BR_JCC: begin
                            // Not taken: PC already points past the operand.
                            if (cond_true) begin
                                l_pc   = 1'b1;
                                pc_sel = PC_OD;
                            end
                        end
                        BR_JR0: begin
                            l_pc   = 1'b1;
                            pc_sel = PC_R0;
                        end
                        BR_CALL: begin
                            if (sp_q == SP_LIMIT) begin
                                err_d   = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                // PC_IN is already past opcode and operand: the return address.
                                dm_we    = 1'b1;
                                dm_addr  = sp_q - 8'd1;
                                dm_wdata = PC_IN;
                                sp_d     = sp_q - 8'd1;
                                l_pc     = 1'b1;
                                pc_sel   = PC_OD;
                            end
                        end
                        BR_RET: begin
                            if (sp_q == SP_INIT) begin
                                err_d   = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                dm_re   = 1'b1;
                                dm_addr = sp_q;
                                state_d = ST_RETLD;
                            end
                        end
                        BR_HLT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
                            // NONE and the reserved encoding.
                            ex_en = 1'b1;
                        end
                    endcase
                end

                ST_RETLD: begin
                    // Read data from the EXEC-cycle DM_RE is valid now.
                    l_pc    = 1'b1;
                    pc_sel  = PC_DM;
                    sp_d    = sp_q + 8'd1;
                    state_d = ST_FETCH;
                end

                ST_HALT: begin
                    state_d = ST_HALT;
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Reset must silence the datapath in the same cycle it is asserted,
    // not just after the edge, so outputs are gated combinationally.
    assign I_PC     = i_pc    & ~RST;
    assign L_PC     = l_pc    & ~RST;
    assign S11      = pc_sel[1] & l_pc & ~RST;
    assign S10      = pc_sel[0] & l_pc & ~RST;
    assign IR_LD    = ir_ld   & ~RST;
    assign OPND_LD  = opnd_ld & ~RST;
    assign EX_EN    = ex_en   & ~RST;
    assign DM_WE    = dm_we   & ~RST;
    assign DM_RE    = dm_re   & ~RST;
    assign DM_ADDR  = RST ? 8'h00 : dm_addr;
    assign DM_WDATA = RST ? 8'h00 : dm_wdata;

    assign SP_OUT   = sp_q;
    assign HALTED   = (state_q == ST_HALT);
    assign STK_ERR  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : self-checking bench for pc_sequencer with a PC/data-memory environment and an
//           instruction-level reference model (PC value, return stack as a queue, fault flags).
// Latency : one DUT cycle per step; inputs driven on negedge, outputs sampled 1 time unit later.
// Backpressure: random STALL cycles inserted before phases; forced stall for the CALL test.
module tb_pc_sequencer;
    import rnbip_pkg::*;

    logic       CLK;
    logic       RST, STALL, HAS_OPND;
    logic [2:0] BR_TYPE, COND, FLAGS;
    logic [7:0] pc;
    logic       I_PC, L_PC, S11, S10, IR_LD, OPND_LD, EX_EN, DM_WE, DM_RE;
    logic [7:0] DM_ADDR, DM_WDATA, SP_OUT;
    logic       HALTED, STK_ERR;

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .HAS_OPND(HAS_OPND), .BR_TYPE(BR_TYPE),
        .COND(COND), .FLAGS(FLAGS), .PC_IN(pc), .I_PC(I_PC), .L_PC(L_PC), .S11(S11),
        .S10(S10), .IR_LD(IR_LD), .OPND_LD(OPND_LD), .EX_EN(EX_EN), .DM_WE(DM_WE),
        .DM_RE(DM_RE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .SP_OUT(SP_OUT),
        .HALTED(HALTED), .STK_ERR(STK_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       i_pc;
        logic       l_pc;
        logic [1:0] sel;
        logic       ir_ld;
        logic       opnd_ld;
        logic       ex_en;
        logic       dm_we;
        logic       dm_re;
        logic [7:0] addr;
        logic [7:0] wdata;
    } strb_t;

    // Environment: operand register, R0, data memory with 1-cycle read latency.
    logic [7:0] opnd_reg, r0, dm_rdata, cur_opnd;
    logic [7:0] dmem [256];

    // Reference model.
    logic [7:0] m_pc;
    logic [7:0] m_stack [$];
    logic       m_err, m_halt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_sp();
        return 8'hFF - 8'(m_stack.size());
    endfunction

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
        logic z, cy, s, v;
        {s, cy, z} = f;
        case (c[1:0])
            2'd0:    v = z;
            2'd1:    v = cy;
            2'd2:    v = s;
            default: v = 1'b1;
        endcase
        return c[2] ? !v : v;
    endfunction

    task automatic do_cycle(input string tag, input logic rst, input logic st, input logic has,
                            input logic [2:0] bt, input logic [2:0] cnd, input logic [2:0] flg,
                            input strb_t exp);
        strb_t obs;
        @(negedge CLK);
        RST = rst; STALL = st; HAS_OPND = has; BR_TYPE = bt; COND = cnd; FLAGS = flg;
        #1;
        obs = {I_PC, L_PC, S11, S10, IR_LD, OPND_LD, EX_EN, DM_WE, DM_RE, DM_ADDR, DM_WDATA};
        check(tag, 32'(obs), 32'(exp));
        @(posedge CLK);
        #1;
        if (obs.i_pc) pc = pc + 8'd1;
        else if (obs.l_pc) begin
            case (obs.sel)
                2'b01:   pc = opnd_reg;
                2'b10:   pc = dm_rdata;
                2'b11:   pc = r0;
                default: pc = pc;
            endcase
        end
        if (obs.opnd_ld) opnd_reg = cur_opnd;
        if (obs.dm_we) dmem[obs.addr] = obs.wdata;
        if (obs.dm_re) dm_rdata = dmem[obs.addr];
    endtask

    task automatic stall_phase(input string tag, input int forced);
        int n;
        n = (forced >= 0) ? forced : (($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
        for (int i = 0; i < n; i++) begin
            do_cycle({tag, "/stall"}, 1'b0, 1'b1, 1'($urandom), 3'($urandom), 3'($urandom),
                     3'($urandom), '0);
            check({tag, "/stall_sp"}, 32'(SP_OUT), 32'(m_sp()));
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/pc"}, 32'(pc), 32'(m_pc));
        check({tag, "/sp"}, 32'(SP_OUT), 32'(m_sp()));
        check({tag, "/stk_err"}, 32'(STK_ERR), 32'(m_err));
        check({tag, "/halted"}, 32'(HALTED), 32'(m_halt));
    endtask

    task automatic do_reset(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++)
            do_cycle({tag, "/rst"}, 1'b1, 1'($urandom), 1'($urandom), 3'($urandom),
                     3'($urandom), 3'($urandom), '0);
        m_stack.delete();
        m_err  = 1'b0;
        m_halt = 1'b0;
        check_status(tag);
    endtask

    task automatic halt_cycles(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            do_cycle({tag, "/halt"}, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom),
                     3'($urandom), 3'($urandom), '0);
            check({tag, "/halted"}, 32'(HALTED), 32'd1);
        end
    endtask

    task automatic run_instr(input string nm, input logic [2:0] bt, input logic has,
                             input logic [2:0] cnd, input logic [2:0] flg, input logic [7:0] opnd,
                             input int exec_stall, input logic rst_retld);
        strb_t      e;
        logic [7:0] sp, p;
        logic       ret_ok;
        sp       = m_sp();
        p        = m_pc + 8'd1 + {7'd0, has};
        ret_ok   = 1'b0;
        cur_opnd = opnd;

        stall_phase({nm, "/f"}, -1);
        e = '0; e.ir_ld = 1'b1; e.i_pc = 1'b1;
        do_cycle({nm, "/fetch"}, 1'b0, 1'b0, 1'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), e);

        stall_phase({nm, "/d"}, -1);
        e = '0; e.opnd_ld = has; e.i_pc = has;
        do_cycle({nm, "/decode"}, 1'b0, 1'b0, has, bt, cnd, 3'($urandom), e);

        stall_phase({nm, "/x"}, exec_stall);
        e = '0;
        case (bt)
            BR_JMP: begin e.l_pc = 1'b1; e.sel = 2'b01; m_pc = opnd; end
            BR_JCC: begin
                if (cond_holds(cnd, flg)) begin e.l_pc = 1'b1; e.sel = 2'b01; m_pc = opnd; end
                else m_pc = p;
            end
            BR_JR0: begin e.l_pc = 1'b1; e.sel = 2'b11; m_pc = r0; end
            BR_CALL: begin
                if (m_stack.size() == 15) begin
                    m_err = 1'b1; m_halt = 1'b1; m_pc = p;
                end else begin
                    e.dm_we = 1'b1; e.addr = sp - 8'd1; e.wdata = p;
                    e.l_pc = 1'b1; e.sel = 2'b01;
                    m_stack.push_back(p);
                    m_pc = opnd;
                end
            end
            BR_RET: begin
                m_pc = p;
                if (m_stack.size() == 0) begin
                    m_err = 1'b1; m_halt = 1'b1;
                end else begin
                    e.dm_re = 1'b1; e.addr = sp;
                    ret_ok = 1'b1;
                end
            end
            BR_HLT: begin m_halt = 1'b1; m_pc = p; end
            default: begin e.ex_en = 1'b1; m_pc = p; end
        endcase
        // Decoder inputs are scrambled here: EXEC must use the registered copies.
        do_cycle({nm, "/exec"}, 1'b0, 1'b0, 1'($urandom), 3'($urandom), 3'($urandom), flg, e);

        if (ret_ok) begin
            if (rst_retld) begin
                do_cycle({nm, "/retld_rst"}, 1'b1, 1'($urandom), 1'($urandom), 3'($urandom),
                         3'($urandom), 3'($urandom), '0);
                m_stack.delete();
                m_err  = 1'b0;
                m_halt = 1'b0;
            end else begin
                stall_phase({nm, "/r"}, -1);
                e = '0; e.l_pc = 1'b1; e.sel = 2'b10;
                do_cycle({nm, "/retld"}, 1'b0, 1'b0, 1'($urandom), 3'($urandom), 3'($urandom),
                         3'($urandom), e);
                m_pc = m_stack.pop_back();
            end
        end
        check_status(nm);
    endtask

    initial begin
        logic [2:0] bt;
        logic       has;
        RST = 1'b1; STALL = 1'b0; HAS_OPND = 1'b0; BR_TYPE = 3'd0; COND = 3'd0; FLAGS = 3'd0;
        pc = 8'h00; m_pc = 8'h00; opnd_reg = 8'h00; r0 = 8'h5A; dm_rdata = 8'h00;
        cur_opnd = 8'h00; m_err = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        do_reset("reset", 3);

        run_instr("none", BR_NONE, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b0);

        pc = 8'h10; m_pc = 8'h10;
        run_instr("jmp", BR_JMP, 1'b1, 3'b011, 3'b000, 8'h40, 0, 1'b0);

        pc = 8'h10; m_pc = 8'h10;
        run_instr("jcc_z0", BR_JCC, 1'b1, 3'b000, 3'b000, 8'h40, 0, 1'b0);
        check("jcc_z0/pc12", 32'(pc), 32'h12);
        pc = 8'h10; m_pc = 8'h10;
        run_instr("jcc_z1", BR_JCC, 1'b1, 3'b000, 3'b001, 8'h40, 0, 1'b0);
        pc = 8'h10; m_pc = 8'h10;
        run_instr("jcc_nz0", BR_JCC, 1'b1, 3'b100, 3'b000, 8'h40, 0, 1'b0);
        pc = 8'h10; m_pc = 8'h10;
        run_instr("jcc_nz1", BR_JCC, 1'b1, 3'b100, 3'b001, 8'h40, 0, 1'b0);

        r0 = 8'hA7;
        run_instr("jr0", BR_JR0, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b0);

        pc = 8'h20; m_pc = 8'h20;
        run_instr("call", BR_CALL, 1'b1, 3'b000, 3'b000, 8'h80, 0, 1'b0);
        check("call/dmem_fe", 32'(dmem[8'hFE]), 32'h22);
        run_instr("ret", BR_RET, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b0);
        check("ret/pc22", 32'(pc), 32'h22);

        run_instr("ret_empty", BR_RET, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b0);
        halt_cycles("ret_empty", 3);
        do_reset("ret_empty", 1);

        for (int i = 0; i < 15; i++)
            run_instr("call_nest", BR_CALL, 1'b1, 3'($urandom), 3'($urandom), 8'($urandom), -1, 1'b0);
        run_instr("call_ovf", BR_CALL, 1'b1, 3'b000, 3'b000, 8'h33, 0, 1'b0);
        halt_cycles("call_ovf", 3);
        do_reset("call_ovf", 1);

        pc = 8'h30; m_pc = 8'h30;
        run_instr("call_stall", BR_CALL, 1'b1, 3'b000, 3'b000, 8'h90, 3, 1'b0);
        run_instr("ret_rst", BR_RET, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b1);
        run_instr("after_rst", BR_NONE, 1'b0, 3'b000, 3'b000, 8'h00, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            bt  = 3'($urandom);
            has = (bt == BR_JMP || bt == BR_JCC || bt == BR_CALL) ? 1'b1 :
                  (bt == BR_NONE || bt == BR_RSV) ? 1'($urandom) : 1'b0;
            r0  = 8'($urandom);
            run_instr("rand", bt, has, 3'($urandom), 3'($urandom), 8'($urandom), -1,
                      ($urandom_range(0, 15) == 0));
            if (m_halt) begin
                halt_cycles("rand", 2);
                do_reset("rand", 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
